// File: rtl/trace_pkg.sv
// Shared types for the retire trace path: memory-op encoding and the packed trace entry.
// With TRACE_TIMESTAMP_EN defined, each entry also carries a 32-bit cycle stamp.
package trace_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_ADDR_W = 9;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    BOTH  = 2'b11
  } mem_op_e;

  typedef struct packed {
    logic                    has_reg;
    logic [REG_IDX_W-1:0]    reg_num;
    logic [TRACE_DATA_W-1:0] reg_data;
    mem_op_e                 mem_op;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] mem_data;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]             cycle;
`endif
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace entries; head and valid are registered, 1-cycle write-to-head.
// Push while full is ignored unless a pop happens in the same cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  trace_entry_t           din,
  output trace_entry_t           dout,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  trace_entry_t      mem_q [DEPTH];
  trace_entry_t      mem_d [DEPTH];
  trace_entry_t      head_q, head_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              rd_en, wr_en;

  assign full  = (count_q == LVL_W'(DEPTH));
  assign rd_en = pop && valid_q;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + LVL_W'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - LVL_W'(1);
    end
    valid_d = (count_d != '0);
    // The new head may be the entry being written this very cycle.
    head_d = '0;
    if (valid_d) begin
      if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
        head_d = din;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign dout  = head_q;
  assign valid = valid_q;
  assign level = count_q;

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures per-cycle retire effects (reg write / data-mem access) into a FWFT trace FIFO, 1-cycle latency.
// Never stalls the core: entries arriving while full with no drain are dropped and counted. Option: TRACE_TIMESTAMP_EN.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_write_sig,
  input  logic [REG_IDX_W-1:0]   reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_has_reg,
  output logic [REG_IDX_W-1:0]   out_reg_num,
  output logic [DATA_W-1:0]      out_reg_data,
  output logic [1:0]             out_mem_op,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_mem_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]            out_cycle
`endif
);

  // The entry layout is fixed by the package, so the widths must agree with it.
  if (DATA_W != TRACE_DATA_W || ADDR_W != TRACE_ADDR_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
  begin : g_bad_cfg
    $error("retire_trace_buffer: unsupported parameter set");
  end

  trace_entry_t      entry, head;
  logic              has_reg, push, pop, full, drop;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  assign has_reg = reg_write_sig && (reg_num != '0);
  assign push    = has_reg || wr || rd;
  assign pop     = out_valid && out_ready;
  assign drop    = push && full && !pop;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] cycle_q, cycle_d;
  assign cycle_d = cycle_q + 32'd1;
`endif

  always_comb begin
    entry         = '0;
    entry.has_reg = has_reg;
    entry.mem_op  = mem_op_e'({wr, rd});
    if (has_reg) begin
      entry.reg_num  = reg_num;
      entry.reg_data = reg_data;
    end
    if (wr || rd) begin
      entry.addr     = addr;
      entry.mem_data = wr ? wr_data : rd_data;
    end
`ifdef TRACE_TIMESTAMP_EN
    entry.cycle = cycle_q;
`endif
  end

  always_comb begin
    overflow_d = overflow_q || drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef TRACE_TIMESTAMP_EN
      cycle_q    <= '0;
`endif
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
      cycle_q    <= cycle_d;
`endif
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .valid (out_valid),
    .full  (full),
    .level (level)
  );

  assign out_has_reg  = head.has_reg;
  assign out_reg_num  = head.reg_num;
  assign out_reg_data = head.reg_data;
  assign out_mem_op   = head.mem_op;
  assign out_addr     = head.addr;
  assign out_mem_data = head.mem_data;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;
`ifdef TRACE_TIMESTAMP_EN
  assign out_cycle    = head.cycle;
`endif

endmodule
